prbs_lfsr_checker: RTL
======================

Name: prbs_lfsr_checker

Overview:
- Serial receive-side counterpart of the team's Fibonacci LFSR pattern generators.
- Consumes a qualified bitstream, self-synchronises its own LFSR copy to the incoming sequence, then counts bit errors.
- Declares or drops lock from windowed error statistics.
- Sits on the far end of a link, UART or loopback under test, driven by the LFSR generator on the transmit side.

Parameters:
- WIDTH, 5: LFSR length in bits (>=3).
- TAP, 1: second feedback tap index. Prediction = sreg[WIDTH-1] ^ sreg[TAP]. Default gives x^5+x^2+1, maximal length 31.
- LOCK_COUNT, 16: consecutive correct predictions required to declare lock (>=1).
- WINDOW, 64: valid-bit window length for loss-of-lock evaluation (>=2).
- LOSS_THRESH, 4: errors within one window that force loss of lock (1..WINDOW).
- CNT_W, 16: error counter width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- bit_in  in  1  received serial bit
- bit_valid  in  1  bit_in qualifier; one bit consumed per cycle when high
- err_clear  in  1  synchronous clear of err_count
- locked  out  1  high while in LOCKED state
- err_pulse  out  1  one-cycle pulse per detected error (LOCKED only)
- err_count  out  CNT_W  saturating error total
- state  out  2  0=SEARCH, 1=CHECK, 2=LOCKED (debug)

Behaviour:
- Reset, asynchronous: state=SEARCH, sreg=0, fill/match/window counters=0, locked=0, err_pulse=0, err_count=0.
- Reset deassertion mid-operation needs no special handling; the next valid bit starts a fresh SEARCH.
- All updates occur only on cycles with bit_valid=1. With bit_valid=0, all state holds and err_pulse=0.
- Let p = sreg[WIDTH-1] ^ sreg[TAP] and b = bit_in.
- SEARCH:
  - sreg <= {sreg[WIDTH-2:0], b}; fill++.
  - On the WIDTH-th bit, go to CHECK with match=0.
- CHECK:
  - sreg <= {sreg[WIDTH-2:0], b} (self-synchronising).
  - If sreg != 0 and b == p: match++.
  - On the LOCK_COUNT-th match, go to LOCKED and clear the window counters.
  - If b != p, or sreg == 0: go to SEARCH with fill=1, counting this bit. All-zero is the lock-up state and must never lock.
- LOCKED:
  - sreg <= {sreg[WIDTH-2:0], p}. The checker free-runs, so a single received error never corrupts the predictor.
  - If b != p: err_pulse=1 next cycle, err_count++ (saturates at all-ones), win_err++.
  - win_bits++ on every valid bit. When win_bits reaches WINDOW, clear win_bits and win_err in that same update.
  - If an error makes win_err reach LOSS_THRESH: go to SEARCH with fill=0, sreg=0, locked drops. This takes priority over window rollover.
- Latency: locked rises the cycle after the LOCK_COUNT-th matching bit is sampled. err_pulse is the cycle after the errored bit is sampled. All outputs are registered.
- err_clear:
  - Zeroes err_count on the next edge in any state.
  - If an error occurs in the same cycle, the clear wins and the result is 0.
  - Does not affect lock or window counters.
- err_count:
  - Increments only in LOCKED.
  - Holds its value across loss of lock and relock.
  - Cleared only by reset or err_clear.
- Minimum time to lock: WIDTH + LOCK_COUNT valid bits (21 at defaults).

Test Plan:
1. Generator seeded 5'h1f, emitted bit = new feedback bit (stream 0,0,1,1,0,...), bit_valid=1 continuously -> locked rises after the 21st bit; err_count=0 after 500 bits; err_pulse never asserts.
2. Clean lock, then invert bit_in on the 100th bit only -> exactly one err_pulse, err_count=1, locked stays 1, no further errors.
3. Locked, invert 4 bits within one 64-bit window -> locked drops the cycle after the 4th error, state=0. Clean stream then relocks after 21 valid bits. err_count=4 is retained.
4. Locked, invert 3 bits in one window and 3 in the next -> no loss of lock, err_count=6.
5. Constant bit_in=0 for 200 bits, then bit_valid toggled at 50% with a valid PRBS stream -> never locks on zeros; then locks after 21 valid bits regardless of gaps, and state holds through gaps.
6. CNT_W=4 with 20 errors injected below threshold -> err_count saturates at 15. err_clear coincident with an error -> 0. rst_n pulsed low mid-lock -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/prbs_lfsr_checker.sv
// Receive-side PRBS checker: self-synchronises a Fibonacci LFSR copy to the
// incoming bitstream, declares lock, then counts bit errors in free-run mode.
module prbs_lfsr_checker #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned TAP         = 1,
  parameter int unsigned LOCK_COUNT  = 16,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             err_clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int unsigned FILL_W  = $clog2(WIDTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WBITS_W = $clog2(WINDOW + 1);
  localparam int unsigned WERR_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_nxt;

  logic [WIDTH-1:0]   r_sreg;
  logic [FILL_W-1:0]  r_fill;
  logic [MATCH_W-1:0] r_match;
  logic [WBITS_W-1:0] r_win_bits;
  logic [WERR_W-1:0]  r_win_err;
  logic [CNT_W-1:0]   r_err_count;
  logic               r_locked;
  logic               r_err_pulse;

  logic [WIDTH-1:0]   w_sreg_nxt;
  logic [FILL_W-1:0]  w_fill_nxt;
  logic [MATCH_W-1:0] w_match_nxt;
  logic [WBITS_W-1:0] w_win_bits_nxt;
  logic [WERR_W-1:0]  w_win_err_nxt;
  logic [CNT_W-1:0]   w_err_count_nxt;
  logic               w_err_hit;

  logic               w_pred;
  logic               w_mismatch;
  logic               w_sreg_zero;
  logic               w_check_ok;
  logic               w_fill_done;
  logic               w_match_done;
  logic               w_win_end;
  logic               w_loss;
  logic               w_cnt_sat;

  // Prediction and per-bit qualifiers shared by both combinational processes
  assign w_pred       = r_sreg[WIDTH-1] ^ r_sreg[TAP];
  assign w_mismatch   = bit_in ^ w_pred;
  assign w_sreg_zero  = (r_sreg == '0);
  assign w_check_ok   = !w_sreg_zero && !w_mismatch;
  assign w_fill_done  = (r_fill == FILL_W'(WIDTH - 1));
  assign w_match_done = (r_match == MATCH_W'(LOCK_COUNT - 1));
  assign w_win_end    = (r_win_bits == WBITS_W'(WINDOW - 1));
  assign w_loss       = w_mismatch && (r_win_err == WERR_W'(LOSS_THRESH - 1));
  assign w_cnt_sat    = &r_err_count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (bit_valid) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_fill_done) begin
            w_state_nxt = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!w_check_ok) begin
            w_state_nxt = ST_SEARCH;
          end else if (w_match_done) begin
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (w_loss) begin
            w_state_nxt = ST_SEARCH;
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    w_sreg_nxt      = r_sreg;
    w_fill_nxt      = r_fill;
    w_match_nxt     = r_match;
    w_win_bits_nxt  = r_win_bits;
    w_win_err_nxt   = r_win_err;
    w_err_hit       = 1'b0;
    if (bit_valid) begin
      case (r_state)
        ST_SEARCH: begin
          w_sreg_nxt = {r_sreg[WIDTH-2:0], bit_in};
          w_fill_nxt = r_fill + FILL_W'(1);
          if (w_fill_done) begin
            w_match_nxt = '0;
          end
        end
        ST_CHECK: begin
          w_sreg_nxt = {r_sreg[WIDTH-2:0], bit_in};
          if (w_check_ok) begin
            w_match_nxt = r_match + MATCH_W'(1);
            if (w_match_done) begin
              w_win_bits_nxt = '0;
              w_win_err_nxt  = '0;
            end
          end else begin
            // The bit that broke the match is the first bit of the new fill
            w_fill_nxt = FILL_W'(1);
          end
        end
        ST_LOCKED: begin
          // Free-run on the prediction so received errors never reach the LFSR
          w_sreg_nxt = {r_sreg[WIDTH-2:0], w_pred};
          w_err_hit  = w_mismatch;
          if (w_loss) begin
            w_sreg_nxt     = '0;
            w_fill_nxt     = '0;
            w_win_bits_nxt = '0;
            w_win_err_nxt  = '0;
          end else if (w_win_end) begin
            w_win_bits_nxt = '0;
            w_win_err_nxt  = '0;
          end else begin
            w_win_bits_nxt = r_win_bits + WBITS_W'(1);
            w_win_err_nxt  = r_win_err + WERR_W'(w_mismatch);
          end
        end
        default: begin
          w_sreg_nxt = '0;
          w_fill_nxt = '0;
        end
      endcase
    end

    w_err_count_nxt = r_err_count;
    if (err_clear) begin
      w_err_count_nxt = '0;
    end else if (w_err_hit && !w_cnt_sat) begin
      w_err_count_nxt = r_err_count + CNT_W'(1);
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg      <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win_bits  <= '0;
      r_win_err   <= '0;
      r_err_count <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_sreg      <= w_sreg_nxt;
      r_fill      <= w_fill_nxt;
      r_match     <= w_match_nxt;
      r_win_bits  <= w_win_bits_nxt;
      r_win_err   <= w_win_err_nxt;
      r_err_count <= w_err_count_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_err_pulse <= w_err_hit;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign state     = r_state;

endmodule
